conv_frame_sequencer: RTL

- Frame-level controller for the streaming convolver datapath.
- Accepts one raster-ordered IMAGE_SIZE x IMAGE_SIZE frame per start command and drives shift_en into the line-buffer/window datapath.
- Marks which accepted pixels complete a valid KERNEL_SIZE x KERNEL_SIZE window, delays that mark by the fixed MAC pipeline latency, and reports the output coordinates.
- Provides busy/done for the layer-level scheduler.

---
 rtl/conv_frame_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/conv_frame_sequencer.sv
// Frame-level controller for the streaming convolver: accepts a raster frame, marks
// window-completing pixels and reports output coordinates. Optional: CONV_SEQ_STALL_CNT_EN.
module conv_frame_sequencer #(
    parameter int unsigned IMAGE_SIZE   = 28,
    parameter int unsigned KERNEL_SIZE  = 5,
    parameter int unsigned CONV_LATENCY = 3,
    localparam int unsigned OUT_N = IMAGE_SIZE - KERNEL_SIZE + 1,
    localparam int unsigned OW    = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          clear,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic          shift_en,
    output logic          out_valid,
    output logic [OW-1:0] out_row,
    output logic [OW-1:0] out_col,
    output logic          busy,
    output logic          done
`ifdef CONV_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int unsigned CW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int unsigned DW = $clog2(CONV_LATENCY + 1);

    localparam logic [CW-1:0] PIX_LAST = CW'(IMAGE_SIZE - 1);
    localparam logic [CW-1:0] WIN_MIN  = CW'(KERNEL_SIZE - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(OUT_N - 1);
    localparam logic [DW-1:0] DRAIN_LD = DW'(CONV_LATENCY);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           row_q, row_d;
    logic [CW-1:0]           col_q, col_d;
    logic [DW-1:0]           drain_q, drain_d;
    logic [OW-1:0]           orow_q, orow_d;
    logic [OW-1:0]           ocol_q, ocol_d;
    logic [CONV_LATENCY-1:0] dly_q, dly_d;
    logic                    win_mark;

`ifdef CONV_SEQ_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            drain_q <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            drain_q <= drain_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            dly_q   <= dly_d;
        end
    end

`ifdef CONV_SEQ_STALL_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (clear) begin
            stall_d = '0;
        end else if (state_q == StIdle && start) begin
            stall_d = '0;
        end else if (state_q == StRun && !pix_valid && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

    always_comb begin
        pix_ready = (state_q == StRun);
        shift_en  = pix_valid & pix_ready;
        out_valid = dly_q[CONV_LATENCY-1];
        out_row   = orow_q;
        out_col   = ocol_q;
        busy      = (state_q == StRun) || (state_q == StDrain);
        done      = (state_q == StDone);
    end

    // Counters are sampled before this cycle's increment.
    assign win_mark = shift_en && (row_q >= WIN_MIN) && (col_q >= WIN_MIN);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        drain_d = drain_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;

        // Non-stallable: matches the fixed-latency MAC pipeline.
        dly_d    = '0;
        dly_d[0] = win_mark;
        for (int i = 1; i < int'(CONV_LATENCY); i++) begin
            dly_d[i] = dly_q[i-1];
        end

        if (out_valid) begin
            if (ocol_q == OUT_LAST) begin
                ocol_d = '0;
                orow_d = (orow_q == OUT_LAST) ? '0 : orow_q + 1'b1;
            end else begin
                ocol_d = ocol_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    row_d   = '0;
                    col_d   = '0;
                    orow_d  = '0;
                    ocol_d  = '0;
                end
            end
            StRun: begin
                if (shift_en) begin
                    if (col_q == PIX_LAST) begin
                        col_d = '0;
                        if (row_q == PIX_LAST) begin
                            row_d   = '0;
                            state_d = StDrain;
                            drain_d = DRAIN_LD;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                drain_d = drain_q - 1'b1;
                if (drain_q == DW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort drops the frame and any results still in the MAC pipeline.
        if (clear) begin
            state_d = StIdle;
            row_d   = '0;
            col_d   = '0;
            drain_d = '0;
            orow_d  = '0;
            ocol_d  = '0;
            dly_d   = '0;
        end
    end

endmodule
